// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings for the pipeline front-end hazard control
package pipe_pkg;
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LU_STALL  = 2'd1,
        ST_IMEM_WAIT = 2'd2
    } state_t;
    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones, cleared by rst or clr
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    // clear wins over increment; hold once all-ones is reached
    always_ff @(posedge clk)
        if (rst || clr) q <= '0;
        else if (inc && q != '1) q <= q + W'(1);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: PC enable and IF/ID, ID/EX hold/flush sequencing with perf counters
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_br_taken,
    input  logic             imem_ready,
    input  logic             clr_cnt,
    output logic             pc_we,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    state_t     state, state_n;
    logic [3:0] lu_cnt, lu_cnt_n;
    logic       lu_haz, lu_act, wait_act;

    assign lu_haz = ex_mem_read && ex_rd != REG_ZERO &&
                    ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));

    // state and stall-length register
    always_ff @(posedge clk)
        if (rst) begin
            state  <= ST_RUN;
            lu_cnt <= 4'd0;
        end else begin
            state  <= state_n;
            lu_cnt <= lu_cnt_n;
        end

    // next state: branch beats load-use beats imem wait; the stall is not re-evaluated
    always_comb begin
        state_n  = ST_RUN;
        lu_cnt_n = lu_cnt;
        if (ex_br_taken) begin
            lu_cnt_n = 4'd0;
        end else if (state == ST_LU_STALL) begin
            lu_cnt_n = lu_cnt - 4'd1;
            state_n  = lu_cnt == 4'd1 ? ST_RUN : ST_LU_STALL;
        end else if (lu_haz) begin
            lu_cnt_n = LU_STALL_CYCLES > 1 ? 4'(LU_STALL_CYCLES - 1) : 4'd0;
            state_n  = LU_STALL_CYCLES > 1 ? ST_LU_STALL : ST_RUN;
        end else if (!imem_ready) begin
            state_n  = ST_IMEM_WAIT;
        end
    end

    // Mealy controls; reset forces a frozen PC with both registers bubbled
    always_comb begin
        lu_act     = !ex_br_taken && (state == ST_LU_STALL || lu_haz);
        wait_act   = !ex_br_taken && !lu_act && !imem_ready;
        pc_we      = !rst && !lu_act && !wait_act;
        ifid_hold  = !rst && lu_act;
        ifid_flush = rst || ex_br_taken || wait_act;
        idex_flush = rst || ex_br_taken || lu_act;
    end

    // control invariants
    always_ff @(posedge clk) begin
        assert (!(ifid_hold && ifid_flush));
        assert (pc_we || ifid_hold || ifid_flush);
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(!pc_we), .q(stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(ex_br_taken), .q(flush_cnt)
    );
endmodule
